clk_div_bank: RTL

- Parametrised bank of NCH independent clock dividers, all driven from one input clock.
- Each channel has a runtime-programmable period and high time, so the duty cycle is selectable.
- Each channel also has a per-channel enable and a one-cycle tick strobe at the start of every period.
- Sits beside the timing/tick logic of the digital-lab designs and replaces fixed single-ratio dividers; new settings are double-buffered so they take effect only at a period boundary.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_chan.sv | 92 +++++++++
 rtl/clk_div_bank.sv | 88 ++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Purpose: shared constants, config payload type and high-time clamp for the
//          clk_div_bank divider bank.
package clk_div_pkg;

  localparam int unsigned CFG_W    = 16;
  localparam int unsigned DEF_DIV  = 4;
  localparam int unsigned DEF_HIGH = 2;

  // One channel's divider setting: period and high time in clkin cycles.
  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } chan_cfg_t;

  // Force high time into 1..div-1 so every period has both phases.
  function automatic logic [CFG_W-1:0] clamp_high(input logic [CFG_W-1:0] div,
                                                  input logic [CFG_W-1:0] high);
    logic [CFG_W-1:0] h;
    h = high;
    if (h == '0) h = CFG_W'(1);
    if (h >= div) h = div - CFG_W'(1);
    return h;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// Purpose: one divider channel with double-buffered period/high-time config.
// Ports:
//   clkin   - clock (posedge)
//   reset   - synchronous active-low reset
//   en      - run enable; low forces count, clkout and tick to 0
//   wr      - load shadow config (only asserted while pending is low)
//   wr_div  - new period, already validated (>= 2)
//   wr_high - new high time, already clamped
//   clkout  - registered divided clock
//   tick    - registered one-cycle pulse in the first cycle of each period
//   pending - shadow config waiting for the next period boundary
module clk_div_chan
  import clk_div_pkg::CFG_W;
  import clk_div_pkg::chan_cfg_t;
#(
  parameter int unsigned W        = CFG_W,
  parameter int unsigned DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter int unsigned DEF_HIGH = clk_div_pkg::DEF_HIGH
) (
  input  logic         clkin,
  input  logic         reset,
  input  logic         en,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  input  logic [W-1:0] wr_high,
  output logic         clkout,
  output logic         tick,
  output logic         pending
);

  logic [W-1:0] count_q, count_d;
  chan_cfg_t    act_q, act_d;
  chan_cfg_t    shd_q, shd_d;
  logic         pending_q, pending_d;
  logic         clkout_q, clkout_d;
  logic         tick_q, tick_d;
  logic         wrap_c;
  logic         apply_c;

  // Next-state: counter, boundary apply of the shadow config, outputs from next count.
  always_comb begin
    act_d     = act_q;
    shd_d     = shd_q;
    pending_d = pending_q;
    count_d   = count_q;
    wrap_c    = (count_q == act_q.div);
    apply_c   = pending_q && (!en || wrap_c);

    if (!en)                          count_d = '0;
    else if (count_q == '0 || wrap_c) count_d = W'(1);
    else                              count_d = count_q + W'(1);

    if (apply_c) begin
      act_d     = shd_q;
      pending_d = 1'b0;
    end

    // wr and apply never coincide: the top only writes while pending is low.
    if (wr) begin
      shd_d.div  = wr_div;
      shd_d.high = wr_high;
      pending_d  = 1'b1;
    end

    clkout_d = (count_d != '0) && (count_d <= act_d.high);
    tick_d   = (count_d == W'(1));
  end

  // State registers.
  always_ff @(posedge clkin) begin
    if (!reset) begin
      count_q   <= '0;
      act_q     <= '{div: W'(DEF_DIV), high: W'(DEF_HIGH)};
      shd_q     <= '{div: W'(DEF_DIV), high: W'(DEF_HIGH)};
      pending_q <= 1'b0;
      clkout_q  <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      act_q     <= act_d;
      shd_q     <= shd_d;
      pending_q <= pending_d;
      clkout_q  <= clkout_d;
      tick_q    <= tick_d;
    end
  end

  assign clkout  = clkout_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_bank.sv
// Purpose: bank of NCH independent programmable clock dividers sharing one
//          config write port.
// Ports:
//   clkin     - clock (posedge)
//   reset     - synchronous active-low reset
//   ch_en     - per-channel run enable
//   cfg_valid - config write request
//   cfg_ready - combinational: addressed channel has no pending update
//   cfg_ch    - target channel
//   cfg_div   - new period
//   cfg_high  - new high time (clamped into 1..div-1)
//   cfg_err   - registered pulse: the accepted write was rejected
//   clkout    - divided clocks, registered
//   tick      - period-start strobes, registered
//   pending   - per-channel shadow config waiting to be applied
module clk_div_bank
  import clk_div_pkg::CFG_W;
  import clk_div_pkg::clamp_high;
#(
  parameter  int unsigned NCH      = 4,
  parameter  int unsigned W        = CFG_W,
  parameter  int unsigned DEF_DIV  = clk_div_pkg::DEF_DIV,
  parameter  int unsigned DEF_HIGH = clk_div_pkg::DEF_HIGH,
  localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clkin,
  input  logic           reset,
  input  logic [NCH-1:0] ch_en,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  input  logic [W-1:0]   cfg_high,
  output logic           cfg_err,
  output logic [NCH-1:0] clkout,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] pending
);

  logic           xfer_c;
  logic           bad_c;
  logic [W-1:0]   high_cl_c;
  logic [NCH-1:0] wr_c;
  logic           cfg_err_q, cfg_err_d;

  // Write decode: out-of-range channels are always ready so a bad write completes.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_ch == CW'(i)) cfg_ready = !pending[i];
    end
    xfer_c    = cfg_valid && cfg_ready;
    bad_c     = xfer_c && ((32'(cfg_ch) >= NCH) || (cfg_div < W'(2)));
    high_cl_c = clamp_high(cfg_div, cfg_high);
    wr_c      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (xfer_c && !bad_c && (cfg_ch == CW'(i))) wr_c[i] = 1'b1;
    end
    cfg_err_d = bad_c;
  end

  // Error pulse register.
  always_ff @(posedge clkin) begin
    if (!reset) cfg_err_q <= 1'b0;
    else        cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_chan #(
      .W        (W),
      .DEF_DIV  (DEF_DIV),
      .DEF_HIGH (DEF_HIGH)
    ) u_chan (
      .clkin   (clkin),
      .reset   (reset),
      .en      (ch_en[g]),
      .wr      (wr_c[g]),
      .wr_div  (cfg_div),
      .wr_high (high_cl_c),
      .clkout  (clkout[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule
